bram_self_clear: RTL and testbench
==================================

// Module: bram_self_clear
// PURPOSE
//  Single-port synchronous block RAM that zeroes its whole array after reset.
//  A counter writes 0 to every entry, one entry per clock, before the RAM accepts
//  user accesses; o_initialized flags completion. Used as tag/data store in caches
//  (e.g. the CPU instruction cache), where an all-zero entry means "invalid line".
// PARAMETERS
//  WIDTH     32  data word width in bits
//  SIZE      1024 number of entries (power of two, >=2); AW = $clog2(SIZE)
//  ADDR_LSH  2   right shift applied to i_address before indexing (byte->word)
// PORTS
//  i_clock        in   1      single clock, all logic on rising edge
//  i_reset        in   1      asynchronous, active-low reset (0 = reset)
//  o_initialized  out  1      1 once the clear sweep has finished
//  i_request      in   1      access strobe, sampled every edge
//  i_rw           in   1      1 = write, 0 = read
//  i_address      in   32     address; index = i_address[ADDR_LSH +: AW]
//  i_wdata        in   WIDTH  write data
//  o_rdata        out  WIDTH  registered read data
//  o_ready        out  1      1-cycle pulse: access accepted on previous edge
// BEHAVIOUR
//  Reset (i_reset=0, async): clr_idx<=0, o_initialized<=0, o_ready<=0, o_rdata<=0;
//   held in reset nothing else changes. Power-up initial values equal reset values,
//   so the sweep also runs without a reset pulse.
//  States: CLEAR -> RUN.
//  CLEAR: each edge write mem[clr_idx]<=0, clr_idx++; after write of entry SIZE-1
//   go RUN and set o_initialized<=1 (visible SIZE edges after reset release).
//   User requests during CLEAR are ignored: no write, o_ready stays 0, o_rdata holds.
//  RUN: o_initialized stays 1 until next reset.
//   read  (i_request=1,i_rw=0): o_rdata<=mem[idx], o_ready<=1 (latency 1 cycle).
//   write (i_request=1,i_rw=1): mem[idx]<=i_wdata, o_ready<=1, o_rdata holds.
//   i_request=0: o_ready<=0, o_rdata holds, memory unchanged.
//  i_request may stay high continuously; every edge is a new access
//   (back-to-back throughput 1/cycle, o_ready high every such cycle).
//  Read of an address written on the previous edge returns the new data.
//  Address bits above ADDR_LSH+AW-1 and below ADDR_LSH are ignored (aliasing/wrap).
//  Reset asserted mid-sweep or mid-access: sweep restarts from entry 0; a write in
//   flight at the reset edge is not guaranteed; all entries are zero after sweep.
//  No read-during-clear data path: o_rdata never shows partially cleared content.
// STRUCTURE
//  No shared package needed; AW derived locally via $clog2.
//  Memory array kept in one always block (no reset on array) so it infers BRAM;
//   write port muxed between clear sweep and user write.
//  Optional sub-module bram_clear_seq: clr_idx counter + CLEAR/RUN flag.
// TESTING
//  1 Reset release, i_request=0 -> o_initialized=0 for SIZE cycles, 1 at edge SIZE.
//  2 After init, read addr 0x10 (ADDR_LSH=2) -> next cycle o_ready=1, o_rdata=0.
//  3 Write 0xDEADBEEF @0x20 then read @0x20 next cycle -> o_rdata=0xDEADBEEF,
//    o_ready high both cycles.
//  4 Request (write 0x5) during CLEAR -> o_ready=0; after init read same addr -> 0.
//  5 Write 0x1234 @0x8, pulse i_reset low mid-run -> o_initialized=0, after new
//    sweep read @0x8 -> 0.
//  6 Alias: SIZE=16, write 0xA @0x4, read @(0x4+16*4) -> 0xA.

Source files
------------

// File: rtl/bram_self_clear_pkg.sv
// rtl/bram_self_clear_pkg.sv - shared types for the self-clearing block RAM
package bram_self_clear_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } clr_state_t;

endpackage

// File: rtl/bram_self_clear_if.sv
// rtl/bram_self_clear_if.sv - user access port of the self-clearing block RAM
interface bram_self_clear_if
    import bram_self_clear_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic              i_request;
    logic              i_rw;
    logic [ADDR_W-1:0] i_address;
    logic [WIDTH-1:0]  i_wdata;
    logic [WIDTH-1:0]  o_rdata;
    logic              o_ready;

    modport master (
        output i_request, i_rw, i_address, i_wdata,
        input  o_rdata, o_ready
    );

    modport slave (
        input  i_request, i_rw, i_address, i_wdata,
        output o_rdata, o_ready
    );
endinterface

// File: rtl/bram_self_clear_seq.sv
// rtl/bram_self_clear_seq.sv - clear sweep counter and CLEAR/RUN state
module bram_self_clear_seq
    import bram_self_clear_pkg::*;
#(
    parameter int SIZE = 1024,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    output logic          o_clearing,
    output logic [AW-1:0] o_clr_idx,
    output logic          o_initialized
);
    clr_state_t    r_state;
    clr_state_t    w_state_nxt;
    logic [AW-1:0] r_clr_idx;
    logic [AW-1:0] w_clr_idx_nxt;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            ST_CLEAR: begin
                w_clr_idx_nxt = r_clr_idx + AW'(1);
                if (r_clr_idx == AW'(SIZE - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    assign o_clearing    = (r_state == ST_CLEAR);
    assign o_clr_idx     = r_clr_idx;
    assign o_initialized = (r_state == ST_RUN);
endmodule

// File: rtl/bram_self_clear.sv
// rtl/bram_self_clear.sv - single-port block RAM that zeroes every entry after reset
module bram_self_clear
    import bram_self_clear_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 1024,
    parameter int ADDR_LSH = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    output logic               o_initialized,
    bram_self_clear_if.slave   bus
);
    localparam int AW = $clog2(SIZE);

    logic [WIDTH-1:0] r_mem [SIZE];
    logic [WIDTH-1:0] r_rdata;
    logic             r_ready;

    logic             w_clearing;
    logic [AW-1:0]    w_clr_idx;
    logic             w_initialized;
    logic [AW-1:0]    w_idx;
    logic             w_access;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_unused_addr;

    bram_self_clear_seq #(
        .SIZE (SIZE),
        .AW   (AW)
    ) u_seq (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .o_clearing    (w_clearing),
        .o_clr_idx     (w_clr_idx),
        .o_initialized (w_initialized)
    );

    // Bits outside the index field alias onto the same entry.
    assign w_idx         = bus.i_address[ADDR_LSH +: AW];
    assign w_unused_addr = ^bus.i_address;

    assign w_access = w_initialized & bus.i_request;
    // Sweep owns the write port until RUN; held-in-reset edges must not write.
    assign w_we     = w_clearing ? i_reset : (w_access & bus.i_rw);
    assign w_waddr  = w_clearing ? w_clr_idx : w_idx;
    assign w_wdata  = w_clearing ? '0 : bus.i_wdata;

    always_ff @(posedge i_clock) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_access;
            if (w_access && !bus.i_rw) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    assign bus.o_rdata    = r_rdata;
    assign bus.o_ready    = r_ready;
    assign o_initialized  = w_initialized;
endmodule

// File: tb/tb_bram_self_clear.sv
// tb/tb_bram_self_clear.sv - self-checking bench for bram_self_clear
module tb_bram_self_clear;
    localparam int WIDTH    = 32;
    localparam int SIZE     = 16;
    localparam int ADDR_LSH = 2;

    logic clk;
    logic rst_n;
    logic init;

    int total;
    int bad;
    bit chk_en;

    bram_self_clear_if #(.WIDTH(WIDTH)) bus ();

    bram_self_clear #(
        .WIDTH    (WIDTH),
        .SIZE     (SIZE),
        .ADDR_LSH (ADDR_LSH)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .o_initialized (init),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: entries live in a plain array; the RAM is usable once SIZE
    // edges have passed since reset release.
    logic [31:0] model_mem [SIZE];
    int          edges_since_rst;
    logic        exp_init;
    logic        exp_ready;
    logic [31:0] exp_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) model_mem[i] = 32'h0;
            edges_since_rst = 0;
            exp_init  = 1'b0;
            exp_ready = 1'b0;
            exp_rdata = 32'h0;
        end else begin
            if (edges_since_rst >= SIZE && bus.i_request) begin
                if (bus.i_rw)
                    model_mem[(bus.i_address >> ADDR_LSH) % SIZE] = bus.i_wdata;
                else
                    exp_rdata = model_mem[(bus.i_address >> ADDR_LSH) % SIZE];
                exp_ready = 1'b1;
            end else begin
                exp_ready = 1'b0;
            end
            edges_since_rst = edges_since_rst + 1;
            exp_init = (edges_since_rst >= SIZE);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_init",  {31'b0, init},        {31'b0, exp_init});
            check("model_ready", {31'b0, bus.o_ready}, {31'b0, exp_ready});
            check("model_rdata", bus.o_rdata,          exp_rdata);
        end
    end

    task automatic cyc(input logic req, input logic rw, input logic [31:0] addr, input logic [31:0] wd);
        bus.i_request = req;
        bus.i_rw      = rw;
        bus.i_address = addr;
        bus.i_wdata   = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        chk_en = 1'b0;
        rst_n = 1'b0;
        bus.i_request = 1'b0;
        bus.i_rw      = 1'b0;
        bus.i_address = 32'h0;
        bus.i_wdata   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_init",  {31'b0, init},        32'h0);
        check("rst_ready", {31'b0, bus.o_ready}, 32'h0);
        check("rst_rdata", bus.o_rdata,          32'h0);

        // Sweep: initialized rises exactly on the SIZE-th edge after release.
        rst_n = 1'b1;
        for (int k = 1; k <= SIZE; k++) begin
            cyc(1'b0, 1'b0, 32'h0, 32'h0);
            check("sweep_init", {31'b0, init}, (k == SIZE) ? 32'h1 : 32'h0);
        end

        cyc(1'b1, 1'b0, 32'h10, 32'h0);
        check("rd10_ready", {31'b0, bus.o_ready}, 32'h1);
        check("rd10_data",  bus.o_rdata,          32'h0);

        cyc(1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
        check("wr20_ready", {31'b0, bus.o_ready}, 32'h1);
        check("wr20_hold",  bus.o_rdata,          32'h0);
        cyc(1'b1, 1'b0, 32'h20, 32'h0);
        check("rd20_ready", {31'b0, bus.o_ready}, 32'h1);
        check("rd20_data",  bus.o_rdata,          32'hDEADBEEF);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        check("idle_ready", {31'b0, bus.o_ready}, 32'h0);
        check("idle_hold",  bus.o_rdata,          32'hDEADBEEF);

        cyc(1'b1, 1'b1, 32'h4, 32'hA);
        cyc(1'b1, 1'b0, 32'h4 + 32'd64, 32'h0);
        check("alias_wrap", bus.o_rdata, 32'hA);
        cyc(1'b1, 1'b0, 32'h8000_0047, 32'h0);
        check("alias_hilo", bus.o_rdata, 32'hA);

        cyc(1'b1, 1'b1, 32'h3C, 32'h77);
        cyc(1'b1, 1'b0, 32'h3C, 32'h0);
        check("last_entry", bus.o_rdata, 32'h77);

        // Back-to-back writes then reads; the model checks every cycle.
        for (int i = 0; i < SIZE; i++)
            cyc(1'b1, 1'b1, 32'(i * 4), 32'h1111_1111 * 32'(i + 1));
        for (int i = SIZE - 1; i >= 0; i--)
            cyc(1'b1, 1'b0, 32'(i * 4), 32'h0);
        check("b2b_rd0", bus.o_rdata, 32'h1111_1111);

        cyc(1'b1, 1'b1, 32'h8, 32'h1234);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #2;
        check("midrst_init",  {31'b0, init},        32'h0);
        check("midrst_ready", {31'b0, bus.o_ready}, 32'h0);
        check("midrst_rdata", bus.o_rdata,          32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc(1'b1, 1'b1, 32'h30, 32'h5);
        check("clr_wr_ready", {31'b0, bus.o_ready}, 32'h0);
        n = 1;
        while (init !== 1'b1 && n < SIZE + 4) begin
            cyc(1'b0, 1'b0, 32'h0, 32'h0);
            n++;
        end
        check("resweep_len", 32'(n), 32'(SIZE));
        cyc(1'b1, 1'b0, 32'h30, 32'h0);
        check("clr_wr_drop", bus.o_rdata, 32'h0);
        cyc(1'b1, 1'b0, 32'h8, 32'h0);
        check("rst_cleared", bus.o_rdata, 32'h0);
        cyc(1'b1, 1'b0, 32'h20, 32'h0);
        check("rst_cleared2", bus.o_rdata, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
